// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared state, pc_op encodings and vector helper for core_sequencer.
package cpu_seq_pkg;

  localparam int STATE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 8'b0000_0001,
    S_DECODE   = 8'b0000_0010,
    S_REG_READ = 8'b0000_0100,
    S_ALU      = 8'b0000_1000,
    S_MEM      = 8'b0001_0000,
    S_REG_WR   = 8'b0010_0000,
    S_PC_DELAY = 8'b0100_0000,
    S_IRQ      = 8'b1000_0000
  } state_t;

  typedef enum logic [1:0] {
    PC_NOP = 2'd0,
    PC_INC = 2'd1,
    PC_SET = 2'd2,
    PC_VEC = 2'd3
  } pc_op_t;

  // Vector slots are two words apart; the sum wraps at 16 bits.
  function automatic logic [15:0] irq_target(input logic [15:0] base, input logic [7:0] idx);
    return base + {7'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder for interrupt requests.
module irq_prio_enc #(
  parameter int LINES = 4,
  parameter int IW    = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic [LINES-1:0] req,
  output logic [IW-1:0]    idx,
  output logic [LINES-1:0] onehot,
  output logic             valid
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx    = '0;
    onehot = '0;
    valid  = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - d16 instruction-cycle sequencer with MEM timeout and vectored IRQ entry.
// Define SEQ_IRQ_EN to build the interrupt path (ie register, IRQ state, priority encoder).
module core_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int          IRQ_LINES   = 4,
  parameter logic [15:0] IRQ_BASE    = 16'h0004,
  parameter int          MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          fetch_data,
  input  logic [3:0]           flags_out,
  input  logic                 en_mem,
  input  logic                 mem_wait,
  input  logic                 should_branch,
  input  logic                 ie_set,
  input  logic                 ie_clr,
  input  logic [IRQ_LINES-1:0] irq,
  input  logic                 bus_err_clr,
  output logic [STATE_W-1:0]   state,
  output logic                 en_decoder,
  output logic                 en_alu,
  output logic                 en_register,
  output logic                 mmio_en,
  output logic                 en_pc,
  output logic [1:0]           pc_op,
  output logic [15:0]          instruction,
  output logic [3:0]           flags_in,
  output logic                 wr_inhibit,
  output logic                 bus_err,
  output logic                 irq_lr_wr,
  output logic [IRQ_LINES-1:0] irq_ack,
  output logic [15:0]          irq_vector
);

  localparam int          IW      = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;
  localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(MEM_TIMEOUT - 1) : 16'd0;

  state_t                 cur;
  state_t                 nxt;
  pc_op_t                 op;
  logic [15:0]            wait_cnt;
  logic                   timeout;
  logic                   irq_take;
  logic [IRQ_LINES-1:0]   enc_req;
  logic [IRQ_LINES-1:0]   enc_onehot;
  logic [IW-1:0]          enc_idx;
  logic                   enc_valid;

  assign timeout = TO_EN && (cur == S_MEM) && mem_wait && (wait_cnt == TO_LAST);

  irq_prio_enc #(
    .LINES (IRQ_LINES),
    .IW    (IW)
  ) u_prio (
    .req    (enc_req),
    .idx    (enc_idx),
    .onehot (enc_onehot),
    .valid  (enc_valid)
  );

`ifdef SEQ_IRQ_EN
  logic                 ie;
  logic [IRQ_LINES-1:0] irq_lat;

  assign irq_take = ie && (|irq);
  // The request is frozen in PC_DELAY so the ack never follows live irq.
  assign enc_req  = irq_lat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie      <= 1'b0;
      irq_lat <= '0;
    end else begin
      if (cur == S_IRQ || ie_clr) begin
        ie <= 1'b0;
      end else if (ie_set) begin
        ie <= 1'b1;
      end
      if (cur == S_PC_DELAY) begin
        irq_lat <= irq;
      end
    end
  end
`else
  logic unused_irq_path;

  assign irq_take        = 1'b0;
  assign enc_req         = '0;
  assign unused_irq_path = ^{irq, ie_set, ie_clr, enc_onehot, enc_idx, enc_valid};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      instruction <= '0;
      flags_in    <= '0;
      wait_cnt    <= '0;
      bus_err     <= 1'b0;
      wr_inhibit  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && !mem_wait) begin
        instruction <= fetch_data;
      end
      if (cur == S_DECODE) begin
        flags_in <= flags_out;
      end
      if (cur == S_ALU) begin
        wait_cnt <= '0;
      end else if (cur == S_MEM && mem_wait) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end else if (bus_err_clr) begin
        bus_err <= 1'b0;
      end
      if (timeout) begin
        wr_inhibit <= 1'b1;
      end else if (cur == S_REG_WR) begin
        wr_inhibit <= 1'b0;
      end
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (!mem_wait) nxt = S_DECODE;
      S_DECODE:   nxt = S_REG_READ;
      S_REG_READ: nxt = S_ALU;
      S_ALU:      nxt = en_mem ? S_MEM : S_REG_WR;
      S_MEM:      if (!mem_wait || timeout) nxt = S_REG_WR;
      S_REG_WR:   nxt = S_PC_DELAY;
      S_PC_DELAY: nxt = irq_take ? S_IRQ : S_FETCH;
      S_IRQ:      nxt = S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  // Strobes are held inactive while reset is asserted.
  always_comb begin
    op          = PC_NOP;
    en_decoder  = 1'b0;
    en_alu      = 1'b0;
    en_register = 1'b0;
    mmio_en     = 1'b0;
    irq_lr_wr   = 1'b0;
    irq_ack     = '0;
    irq_vector  = '0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          if (!mem_wait) op = PC_INC;
        end
        S_DECODE: begin
          en_decoder = 1'b1;
        end
        S_REG_READ: begin
          en_register = 1'b1;
          if (instruction[15]) op = PC_INC;
        end
        S_ALU: begin
          en_alu = 1'b1;
        end
        S_MEM: begin
          mmio_en = 1'b1;
        end
        S_REG_WR: begin
          en_register = 1'b1;
          if (should_branch) op = PC_SET;
        end
`ifdef SEQ_IRQ_EN
        S_IRQ: begin
          if (enc_valid) begin
            op         = PC_VEC;
            irq_lr_wr  = 1'b1;
            irq_ack    = enc_onehot;
            irq_vector = irq_target(IRQ_BASE, 8'(enc_idx));
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = cur;
  assign pc_op = op;
  assign en_pc = (op != PC_NOP);

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized instruction-level check of core_sequencer against a cycle-plan model.
module tb_core_sequencer;

  localparam int          NL      = 4;
  localparam logic [15:0] BASE    = 16'h0004;
  localparam int          MEM_TO  = 8;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_REG_READ = 2, ST_ALU = 3;
  localparam int ST_MEM = 4, ST_REG_WR = 5, ST_PC_DELAY = 6, ST_IRQ = 7;
  localparam logic [1:0] OP_NOP = 2'd0, OP_INC = 2'd1, OP_SET = 2'd2, OP_VEC = 2'd3;

`ifdef SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   fetch_data;
  logic [3:0]    flags_out;
  logic          en_mem, mem_wait, should_branch, ie_set, ie_clr, bus_err_clr;
  logic [NL-1:0] irq;
  logic [7:0]    state;
  logic          en_decoder, en_alu, en_register, mmio_en, en_pc;
  logic [1:0]    pc_op;
  logic [15:0]   instruction;
  logic [3:0]    flags_in;
  logic          wr_inhibit, bus_err, irq_lr_wr;
  logic [NL-1:0] irq_ack;
  logic [15:0]   irq_vector;

  int tests = 0;
  int failed = 0;

  logic [15:0] m_instr;
  logic [3:0]  m_flags;
  bit          m_bus_err, m_wi, m_ie;

  core_sequencer #(
    .IRQ_LINES   (NL),
    .IRQ_BASE    (BASE),
    .MEM_TIMEOUT (MEM_TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_data    (fetch_data),
    .flags_out     (flags_out),
    .en_mem        (en_mem),
    .mem_wait      (mem_wait),
    .should_branch (should_branch),
    .ie_set        (ie_set),
    .ie_clr        (ie_clr),
    .irq           (irq),
    .bus_err_clr   (bus_err_clr),
    .state         (state),
    .en_decoder    (en_decoder),
    .en_alu        (en_alu),
    .en_register   (en_register),
    .mmio_en       (mmio_en),
    .en_pc         (en_pc),
    .pc_op         (pc_op),
    .instruction   (instruction),
    .flags_in      (flags_in),
    .wr_inhibit    (wr_inhibit),
    .bus_err       (bus_err),
    .irq_lr_wr     (irq_lr_wr),
    .irq_ack       (irq_ack),
    .irq_vector    (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic scramble();
    fetch_data    = 16'($urandom);
    flags_out     = 4'($urandom);
    en_mem        = 1'($urandom);
    mem_wait      = 1'($urandom);
    should_branch = 1'($urandom);
    irq           = NL'($urandom);
    ie_set        = ($urandom_range(0, 4) == 0);
    ie_clr        = ($urandom_range(0, 6) == 0);
    bus_err_clr   = ($urandom_range(0, 5) == 0);
  endtask

  // One cycle: compare outputs against the planned stage, then advance the model across the edge.
  task automatic step(input int stg, input logic [1:0] op, input bit to,
                      input logic [NL-1:0] ack, input logic [15:0] vec, input bit lr);
    #1;
    check_eq("state", state, 32'(1) << stg);
    check_eq("pc_op", pc_op, op);
    check_eq("en_pc", en_pc, op != OP_NOP);
    check_eq("en_decoder", en_decoder, stg == ST_DECODE);
    check_eq("en_alu", en_alu, stg == ST_ALU);
    check_eq("en_register", en_register, stg == ST_REG_READ || stg == ST_REG_WR);
    check_eq("mmio_en", mmio_en, stg == ST_MEM);
    check_eq("instruction", instruction, m_instr);
    check_eq("flags_in", flags_in, m_flags);
    check_eq("bus_err", bus_err, m_bus_err);
    check_eq("wr_inhibit", wr_inhibit, m_wi);
    check_eq("irq_ack", irq_ack, ack);
    check_eq("irq_vector", irq_vector, vec);
    check_eq("irq_lr_wr", irq_lr_wr, lr);
    @(posedge clk);
    if (to) begin
      m_bus_err = 1'b1;
      m_wi      = 1'b1;
    end else begin
      if (bus_err_clr) m_bus_err = 1'b0;
      if (stg == ST_REG_WR) m_wi = 1'b0;
    end
    if (IRQ_EN) begin
      if (stg == ST_IRQ || ie_clr) m_ie = 1'b0;
      else if (ie_set) m_ie = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input int fw, input logic [15:0] fd, input logic [3:0] fl, input bit em,
                           input int mw, input bit br, input logic [NL-1:0] irqv);
    bit timed;
    bit take;
    int n;
    int idx;
    for (int k = 0; k <= fw; k++) begin
      scramble();
      mem_wait = (k < fw);
      if (k == fw) fetch_data = fd;
      step(ST_FETCH, (k < fw) ? OP_NOP : OP_INC, 1'b0, '0, 16'h0, 1'b0);
    end
    m_instr = fd;
    scramble();
    flags_out = fl;
    step(ST_DECODE, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    m_flags = fl;
    scramble();
    step(ST_REG_READ, m_instr[15] ? OP_INC : OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    scramble();
    en_mem = em;
    step(ST_ALU, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    if (em) begin
      timed = (mw >= MEM_TO);
      n = timed ? MEM_TO : mw + 1;
      for (int c = 0; c < n; c++) begin
        scramble();
        mem_wait = timed ? 1'b1 : (c < mw);
        step(ST_MEM, OP_NOP, timed && (c == n - 1), '0, 16'h0, 1'b0);
      end
    end
    scramble();
    should_branch = br;
    step(ST_REG_WR, br ? OP_SET : OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    scramble();
    irq = irqv;
    take = IRQ_EN && m_ie && (irqv != '0);
    step(ST_PC_DELAY, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    if (take) begin
      idx = 0;
      for (int i = NL - 1; i >= 0; i--) if (irqv[i]) idx = i;
      scramble();
      step(ST_IRQ, OP_VEC, 1'b0, NL'(1) << idx, BASE + 16'(2 * idx), 1'b1);
    end
  endtask

  task automatic reset_checks();
    check_eq("rst_state", state, 32'h01);
    check_eq("rst_pc_op", pc_op, OP_NOP);
    check_eq("rst_strobes", {en_decoder, en_alu, en_register, mmio_en, en_pc, irq_lr_wr}, 32'h0);
    check_eq("rst_instruction", instruction, 32'h0);
    check_eq("rst_flags_in", flags_in, 32'h0);
    check_eq("rst_bus_err", bus_err, 32'h0);
    check_eq("rst_wr_inhibit", wr_inhibit, 32'h0);
    check_eq("rst_irq_ack", irq_ack, 32'h0);
    check_eq("rst_irq_vector", irq_vector, 32'h0);
  endtask

  task automatic model_reset();
    m_instr   = '0;
    m_flags   = '0;
    m_bus_err = 1'b0;
    m_wi      = 1'b0;
    m_ie      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    scramble();
    mem_wait = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(0, 16'h1234, 4'h5, 1'b0, 0, 1'b0, '0);
    run_instr(0, 16'h8001, 4'hA, 1'b0, 0, 1'b1, '0);
    run_instr(1, 16'h8002, 4'h3, 1'b1, 3, 1'b0, 4'b0110);
    run_instr(0, 16'h0003, 4'hC, 1'b1, 20, 1'b0, 4'b0001);
    run_instr(2, 16'h0004, 4'h6, 1'b1, MEM_TO - 1, 1'b1, 4'b1000);

    for (int t = 0; t < 90; t++) begin
      run_instr($urandom_range(0, 2), 16'($urandom), 4'($urandom), 1'($urandom),
                $urandom_range(0, 11), 1'($urandom), NL'($urandom));
    end

    // Reset in the middle of a MEM wait.
    scramble();
    mem_wait = 1'b0;
    bus_err_clr = 1'b1;
    fetch_data = 16'h4321;
    step(ST_FETCH, OP_INC, 1'b0, '0, 16'h0, 1'b0);
    m_instr = 16'h4321;
    scramble();
    flags_out = 4'h9;
    step(ST_DECODE, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    m_flags = 4'h9;
    scramble();
    step(ST_REG_READ, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    scramble();
    en_mem = 1'b1;
    step(ST_ALU, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    scramble();
    mem_wait = 1'b1;
    step(ST_MEM, OP_NOP, 1'b0, '0, 16'h0, 1'b0);
    scramble();
    mem_wait = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_wait = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(0, 16'h0101, 4'h1, 1'b0, 0, 1'b0, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
